// File: rtl/aha_sif_arbiter_pkg.sv
// rtl/aha_sif_arbiter_pkg.sv - shared types for the two-requester SIF memory arbiter
package aha_sif_arbiter_pkg;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    // One in-flight read: which requester gets the returning data.
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/aha_sif_arbiter_rd_tag_pipe.sv
// rtl/aha_sif_arbiter_rd_tag_pipe.sv - fixed-latency owner tag shift register for read returns
module aha_sif_arbiter_rd_tag_pipe
    import aha_sif_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  rd_tag_t    tag_in,
    output logic [1:0] rvalid
);

    rd_tag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign rvalid = stage[DEPTH-1].valid ? owner_onehot(stage[DEPTH-1].owner) : 2'b00;

endmodule

// File: rtl/aha_sif_arbiter.sv
// rtl/aha_sif_arbiter.sv - round-robin arbiter with bounded burst lock sharing one SIF memory port
module aha_sif_arbiter
    import aha_sif_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RD_WS      = 0,
    parameter int MAX_LOCK   = 16,
    localparam int SW        = DATA_WIDTH / 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [1:0]              REQ,
    input  logic [1:0]              LOCK,
    input  logic [2*SW-1:0]         WEN,
    input  logic [2*ADDR_WIDTH-1:0] ADDR,
    input  logic [2*DATA_WIDTH-1:0] WDATA,
    output logic [1:0]              GNT,
    output logic [1:0]              RVALID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic                    MEM_EN,
    output logic [SW-1:0]           MEM_WE,
    output logic [ADDR_WIDTH-1:0]   MEM_ADDR,
    output logic [DATA_WIDTH-1:0]   MEM_WDATA,
    input  logic [DATA_WIDTH-1:0]   MEM_RDATA
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e       state;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] lock_cnt;

    logic             owner_req;
    logic             other_req;
    logic             hold_lock;
    logic             force_other;
    logic             any_gnt;
    logic             gnt_idx;
    logic             accept;

    logic [SW-1:0]         sel_wen;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    rd_tag_t               rd_tag;

    assign owner_req   = REQ[owner];
    assign other_req   = REQ[~owner];
    assign hold_lock   = (state == ARB_LOCKED) && owner_req;
    // Lock budget spent while the other side waits: hand it exactly one beat.
    assign force_other = hold_lock && other_req && (lock_cnt == CNT_W'(MAX_LOCK));

    always_comb begin
        any_gnt = 1'b0;
        gnt_idx = 1'b0;
        if (force_other) begin
            any_gnt = 1'b1;
            gnt_idx = ~owner;
        end else if (hold_lock) begin
            any_gnt = 1'b1;
            gnt_idx = owner;
        end else if (REQ == 2'b11) begin
            any_gnt = 1'b1;
            gnt_idx = ~last;
        end else if (REQ[0]) begin
            any_gnt = 1'b1;
            gnt_idx = 1'b0;
        end else if (REQ[1]) begin
            any_gnt = 1'b1;
            gnt_idx = 1'b1;
        end
    end

    assign GNT    = any_gnt ? owner_onehot(gnt_idx) : 2'b00;
    assign accept = |(REQ & GNT);

    assign sel_wen   = gnt_idx ? WEN[2*SW-1:SW]                 : WEN[SW-1:0];
    assign sel_addr  = gnt_idx ? ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : ADDR[ADDR_WIDTH-1:0];
    assign sel_wdata = gnt_idx ? WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : WDATA[DATA_WIDTH-1:0];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= ARB_UNLOCKED;
            owner    <= 1'b0;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else if (accept) begin
            last <= gnt_idx;
            if (hold_lock && !force_other) begin
                if (LOCK[owner]) begin
                    if (other_req) begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end else begin
                    state    <= ARB_UNLOCKED;
                    lock_cnt <= '0;
                end
            end else if (LOCK[gnt_idx]) begin
                state    <= ARB_LOCKED;
                owner    <= gnt_idx;
                lock_cnt <= REQ[~gnt_idx] ? CNT_W'(1) : '0;
            end else begin
                state    <= ARB_UNLOCKED;
                lock_cnt <= '0;
            end
        end else if (state == ARB_LOCKED && !owner_req) begin
            state    <= ARB_UNLOCKED;
            lock_cnt <= '0;
        end
    end

    // Address and data hold when idle; only the enables drop.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            MEM_EN    <= 1'b0;
            MEM_WE    <= '0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else if (accept) begin
            MEM_EN    <= 1'b1;
            MEM_WE    <= sel_wen;
            MEM_ADDR  <= sel_addr;
            MEM_WDATA <= sel_wdata;
        end else begin
            MEM_EN <= 1'b0;
            MEM_WE <= '0;
        end
    end

    assign rd_tag.valid = accept && (sel_wen == '0);
    assign rd_tag.owner = gnt_idx;

    aha_sif_arbiter_rd_tag_pipe #(
        .DEPTH (RD_WS + 2)
    ) u_rd_tag_pipe (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .tag_in (rd_tag),
        .rvalid (RVALID)
    );

    assign RDATA = MEM_RDATA;

    gnt_legal: assert property (@(posedge ACLK) disable iff (!ARESETn)
        $onehot0(GNT) && ((GNT & ~REQ) == 2'b00));

endmodule
